// File: rtl/zelda_draw_pkg.sv
// Shared definitions for the frame draw sequencer and the draw responders.
//   draw_seq_state_t       : sequencer state encoding
//   DEFAULT_TIMEOUT_CYCLES : default per-request watchdog limit
//   OVERRUN_CNT_W          : width of the saturating overrun counter
package zelda_draw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAP,
    ST_HUD,
    ST_SPRITE,
    ST_FDONE
  } draw_seq_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 100000;
  localparam int unsigned OVERRUN_CNT_W          = 8;

endpackage

// File: rtl/step_watchdog.sv
// Per-step watchdog shared by the draw states of the sequencer.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : zero the counter (asserted on every state change)
//   enable       : count this cycle (high while a draw request is up)
//   expired      : high in the cycle the count reaches TIMEOUT_CYCLES-1
module step_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 17
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/draw_sequencer.sv
// Frame-level draw initiator: on each frame tick raises draw_map, draw_HUD
// and draw_sprite in order (skipping clean map/HUD layers), advancing on the
// matching done pulse or on watchdog abort.
//   clock, reset         : system clock, synchronous active-high reset
//   frame_tick           : start-of-frame pulse
//   map_dirty, hud_dirty : layer invalidation pulses
//   clear_status         : clears timeout_flag and overrun_count
//   draw_*_done          : responder completion pulses
//   draw_map/HUD/sprite  : level requests to responders
//   busy, frame_done     : sequencer activity / end-of-frame pulse
//   timeout_flag         : sticky watchdog abort indicator
//   overrun_count        : saturating count of ticks dropped while busy
module draw_sequencer
  import zelda_draw_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = 17
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     map_dirty,
  input  logic                     hud_dirty,
  input  logic                     clear_status,
  input  logic                     draw_map_done,
  input  logic                     draw_HUD_done,
  input  logic                     draw_sprite_done,
  output logic                     draw_map,
  output logic                     draw_HUD,
  output logic                     draw_sprite,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     timeout_flag,
  output logic [OVERRUN_CNT_W-1:0] overrun_count
);

  draw_seq_state_t state, state_next;
  logic entry;
  logic map_pend, hud_pend;
  logic map_clr, hud_clr, hud_set_map;
  logic abort, expired, wd_enable, overrun_evt;

  assign wd_enable   = (state == ST_MAP) || (state == ST_HUD) || (state == ST_SPRITE);
  assign overrun_evt = frame_tick && (state != ST_IDLE);

  step_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_next != state),
    .enable (wd_enable),
    .expired(expired)
  );

  // Done inputs are ignored in the entry cycle so a done still held high from
  // the previous step cannot complete the new one. Done beats a same-cycle
  // expiry, so abort is only the no-done branch.
  always_comb begin
    state_next  = state;
    map_clr     = 1'b0;
    hud_clr     = 1'b0;
    hud_set_map = 1'b0;
    abort       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_tick) begin
          if (map_pend)      state_next = ST_MAP;
          else if (hud_pend) state_next = ST_HUD;
          else               state_next = ST_SPRITE;
        end
      end
      ST_MAP: begin
        if (!entry && draw_map_done) begin
          map_clr     = 1'b1;
          hud_set_map = 1'b1;
          state_next  = ST_HUD;
        end else if (expired) begin
          abort      = 1'b1;
          state_next = ST_HUD;
        end
      end
      ST_HUD: begin
        if (!entry && draw_HUD_done) begin
          hud_clr    = 1'b1;
          state_next = ST_SPRITE;
        end else if (expired) begin
          abort      = 1'b1;
          state_next = ST_SPRITE;
        end
      end
      ST_SPRITE: begin
        if (!entry && draw_sprite_done) begin
          state_next = ST_FDONE;
        end else if (expired) begin
          abort      = 1'b1;
          state_next = ST_FDONE;
        end
      end
      ST_FDONE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      entry         <= 1'b0;
      map_pend      <= 1'b1;
      hud_pend      <= 1'b1;
      draw_map      <= 1'b0;
      draw_HUD      <= 1'b0;
      draw_sprite   <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      timeout_flag  <= 1'b0;
      overrun_count <= '0;
    end else begin
      state       <= state_next;
      entry       <= (state_next != state);
      map_pend    <= (map_pend & ~map_clr) | map_dirty;
      hud_pend    <= (hud_pend & ~hud_clr) | hud_dirty | hud_set_map;
      draw_map    <= (state_next == ST_MAP);
      draw_HUD    <= (state_next == ST_HUD);
      draw_sprite <= (state_next == ST_SPRITE);
      busy        <= (state_next != ST_IDLE);
      frame_done  <= (state_next == ST_FDONE);

      if (abort)             timeout_flag <= 1'b1;
      else if (clear_status) timeout_flag <= 1'b0;

      // A coincident clear restarts the count from the new event.
      if (overrun_evt) begin
        if (clear_status)         overrun_count <= OVERRUN_CNT_W'(1);
        else if (overrun_count != '1) overrun_count <= overrun_count + 1'b1;
      end else if (clear_status) begin
        overrun_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
module tb_draw_sequencer;

  logic       clock = 1'b0;
  logic       reset, frame_tick, map_dirty, hud_dirty, clear_status;
  logic       draw_map_done, draw_HUD_done, draw_sprite_done;
  logic       draw_map, draw_HUD, draw_sprite, busy, frame_done, timeout_flag;
  logic [7:0] overrun_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  draw_sequencer #(
    .TIMEOUT_CYCLES(8),
    .CNT_W         (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .map_dirty       (map_dirty),
    .hud_dirty       (hud_dirty),
    .clear_status    (clear_status),
    .draw_map_done   (draw_map_done),
    .draw_HUD_done   (draw_HUD_done),
    .draw_sprite_done(draw_sprite_done),
    .draw_map        (draw_map),
    .draw_HUD        (draw_HUD),
    .draw_sprite     (draw_sprite),
    .busy            (busy),
    .frame_done      (frame_done),
    .timeout_flag    (timeout_flag),
    .overrun_count   (overrun_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  function automatic logic [2:0] reqs();
    return {draw_sprite, draw_HUD, draw_map};
  endfunction

  // Called in the entry cycle of a request; holds it for len cycles, with the
  // done pulse in the last one, and returns in the first cycle after.
  task automatic serve(input int which, input int len, input bit dirty_at_done);
    for (int i = 0; i < len; i++) begin
      check("req_onehot", 32'(reqs()), 32'(3'b001 << which));
      if (i == len - 1) begin
        case (which)
          0:       draw_map_done    = 1'b1;
          1:       draw_HUD_done    = 1'b1;
          default: draw_sprite_done = 1'b1;
        endcase
        if (dirty_at_done) hud_dirty = 1'b1;
      end
      step();
      draw_map_done    = 1'b0;
      draw_HUD_done    = 1'b0;
      draw_sprite_done = 1'b0;
      hud_dirty        = 1'b0;
    end
  endtask

  task automatic end_frame();
    check("fdone_pulse", 32'(frame_done), 1);
    check("fdone_reqs", 32'(reqs()), 0);
    check("fdone_busy", 32'(busy), 1);
    step();
    check("fdone_low", 32'(frame_done), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; map_dirty = 1'b0; hud_dirty = 1'b0;
    clear_status = 1'b0; draw_map_done = 1'b0; draw_HUD_done = 1'b0;
    draw_sprite_done = 1'b0;
    step(); step();
    check("rst_reqs", 32'(reqs()), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fdone", 32'(frame_done), 0);
    check("rst_tflag", 32'(timeout_flag), 0);
    check("rst_ovr", 32'(overrun_count), 0);
    reset = 1'b0;
    step(); step(); step();

    // First frame draws every layer, 6 cycles each, no gaps.
    tick_pulse();
    check("f1_busy", 32'(busy), 1);
    serve(0, 6, 1'b0);
    serve(1, 6, 1'b0);
    serve(2, 6, 1'b0);
    end_frame();

    // Clean frame: sprites only.
    step();
    tick_pulse();
    check("clean_sprite", 32'(reqs()), 3'b100);
    serve(2, 3, 1'b0);
    end_frame();

    // HUD-only frame, with hud_dirty coincident with HUD done.
    hud_dirty = 1'b1; step(); hud_dirty = 1'b0;
    tick_pulse();
    check("hud_only", 32'(reqs()), 3'b010);
    serve(1, 2, 1'b1);
    serve(2, 2, 1'b0);
    end_frame();
    tick_pulse();
    check("hud_again", 32'(reqs()), 3'b010);
    serve(1, 2, 1'b0);
    serve(2, 2, 1'b0);
    end_frame();
    tick_pulse();
    check("hud_cleared", 32'(reqs()), 3'b100);
    serve(2, 2, 1'b0);
    end_frame();

    // Stale done held high into HUD; then wrong-state dones in SPRITE.
    hud_dirty = 1'b1; step(); hud_dirty = 1'b0;
    draw_HUD_done = 1'b1;
    tick_pulse();
    check("stale_entry", 32'(reqs()), 3'b010);
    step();
    check("stale_ignored", 32'(reqs()), 3'b010);
    step();
    check("stale_accepted", 32'(reqs()), 3'b100);
    draw_map_done = 1'b1;
    step(); step();
    draw_HUD_done = 1'b0; draw_map_done = 1'b0;
    check("wrong_done_ignored", 32'(reqs()), 3'b100);
    serve(2, 2, 1'b0);
    end_frame();

    // Hung map responder: request held exactly 8 cycles, then HUD.
    map_dirty = 1'b1; step(); map_dirty = 1'b0;
    tick_pulse();
    check("hang_tflag0", 32'(timeout_flag), 0);
    for (int i = 0; i < 8; i++) begin
      check("hang_map_high", 32'(draw_map), 1);
      step();
    end
    check("hang_abort_reqs", 32'(reqs()), 3'b010);
    check("hang_tflag1", 32'(timeout_flag), 1);
    serve(1, 3, 1'b0);
    serve(2, 3, 1'b0);
    end_frame();
    tick_pulse();
    check("hang_retry_map", 32'(reqs()), 3'b001);
    serve(0, 3, 1'b0);
    serve(1, 3, 1'b0);
    serve(2, 3, 1'b0);
    end_frame();
    clear_status = 1'b1; step(); clear_status = 1'b0;
    check("tflag_cleared", 32'(timeout_flag), 0);

    // Reset during MAP.
    map_dirty = 1'b1; step(); map_dirty = 1'b0;
    tick_pulse();
    step();
    reset = 1'b1;
    step();
    check("midrst_reqs", 32'(reqs()), 0);
    check("midrst_busy", 32'(busy), 0);
    reset = 1'b0;
    step();
    tick_pulse();
    serve(0, 2, 1'b0);
    serve(1, 2, 1'b0);
    serve(2, 2, 1'b0);
    end_frame();

    // Overruns: tick every cycle; sprite steps abort and frames restart.
    tick_pulse();
    for (int i = 0; i < 400; i++) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b0;
    check("ovr_saturated", 32'(overrun_count), 255);
    for (int i = 0; i < 30; i++) step();
    check("ovr_idle", 32'(busy), 0);
    check("ovr_sprite_abort", 32'(timeout_flag), 1);
    check("ovr_hold", 32'(overrun_count), 255);
    clear_status = 1'b1; step(); clear_status = 1'b0;
    check("ovr_cleared", 32'(overrun_count), 0);
    check("ovr_tflag_cleared", 32'(timeout_flag), 0);

    // Tick during FDONE is an overrun.
    tick_pulse();
    serve(2, 2, 1'b0);
    frame_tick = 1'b1;
    check("fdone_tick_pulse", 32'(frame_done), 1);
    step();
    frame_tick = 1'b0;
    check("fdone_tick_ovr", 32'(overrun_count), 1);
    check("fdone_tick_dropped", 32'(busy), 0);

    // Clear coincident with an overrun: event wins.
    tick_pulse();
    frame_tick = 1'b1; clear_status = 1'b1;
    step();
    frame_tick = 1'b0; clear_status = 1'b0;
    check("clr_vs_ovr", 32'(overrun_count), 1);
    serve(2, 2, 1'b0);
    end_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
